// File: rtl/board_pkg.sv
// Shared types and defaults for the board select/commit stage.
package board_pkg;

  localparam int DEF_TILE_W     = 12;
  localparam int DEF_ROWS       = 4;
  localparam int DEF_COLS       = 4;
  localparam int DEF_NUM_SRC    = 4;
  localparam int DEF_UNDO_DEPTH = 4;

  typedef logic [DEF_TILE_W-1:0] tile_t;
  typedef tile_t [DEF_ROWS-1:0][DEF_COLS-1:0] board_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    UNDO = 2'd2,
    DONE = 2'd3
  } fsm_state_t;

  // Index width that stays at least one bit when there is a single choice.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/board_history.sv
// Circular LIFO of past boards; a push when full overwrites the oldest entry.
module board_history #(
  parameter int W     = 192,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  import board_pkg::*;

  localparam int PW = idx_width(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] wp_next;
  logic [PW-1:0] wp_prev;

  assign wp_next = (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
  assign wp_prev = (wp == '0) ? PW'(DEPTH - 1) : wp - PW'(1);
  assign dout    = mem[wp_prev];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      count <= '0;
    end else if (clear) begin
      wp    <= '0;
      count <= '0;
    end else if (push) begin
      wp <= wp_next;
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end else if (pop && (count != '0)) begin
      wp    <= wp_prev;
      count <= count - CW'(1);
    end
  end

  // Storage carries no reset: entries are only ever read below count.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wp] <= din;
  end

endmodule

// File: rtl/board_select_commit.sv
// Registered select of one candidate board, commit to the live board, with undo history.
module board_select_commit
  import board_pkg::*;
#(
  parameter int TILE_W     = DEF_TILE_W,
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int UNDO_DEPTH = DEF_UNDO_DEPTH,
  parameter int BW         = TILE_W * ROWS * COLS,
  parameter int SW         = idx_width(NUM_SRC),
  parameter int CW         = $clog2(UNDO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic [BW-1:0]         init_board,
  input  logic [NUM_SRC*BW-1:0] cand,
  input  logic [SW-1:0]         sel,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  undo_req,
  output logic [BW-1:0]         board,
  output logic                  done,
  output logic                  changed,
  output logic                  err,
  output logic [CW-1:0]         hist_count,
  output logic [1:0]            state_dbg
);

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and nothing presented outside IDLE is kept.

  fsm_state_t state_q, state_d;

  logic [BW-1:0] board_q, cap_q, cand_sel, hist_dout;
  logic          sel_ok, sel_ok_q;
  logic          chg_q, err_q;
  logic          cap_load, init_load, commit, restore, flag_load, chg_d, err_d;
  logic          push, pop, clear;
  logic [31:0]   sel_ext;

  assign sel_ext = 32'(sel);
  assign sel_ok  = sel_ext < 32'(NUM_SRC);

  always_comb begin
    cand_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_ext == 32'(i)) cand_sel = cand[i*BW +: BW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cap_load  = 1'b0;
    init_load = 1'b0;
    commit    = 1'b0;
    restore   = 1'b0;
    flag_load = 1'b0;
    chg_d     = 1'b0;
    err_d     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (init) begin
          init_load = 1'b1;
          clear     = 1'b1;
        end else if (req_valid) begin
          cap_load = 1'b1;
          state_d  = CMP;
        end else if (undo_req) begin
          state_d = UNDO;
        end
      end
      CMP: begin
        flag_load = 1'b1;
        state_d   = DONE;
        if (!sel_ok_q) begin
          err_d = 1'b1;
        end else if (cap_q != board_q) begin
          commit = 1'b1;
          push   = 1'b1;
          chg_d  = 1'b1;
        end
      end
      UNDO: begin
        flag_load = 1'b1;
        state_d   = DONE;
        if (hist_count != '0) begin
          restore = 1'b1;
          pop     = 1'b1;
          chg_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_q  <= '0;
      cap_q    <= '0;
      sel_ok_q <= 1'b0;
      chg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (cap_load) begin
        cap_q    <= cand_sel;
        sel_ok_q <= sel_ok;
      end
      if (init_load)    board_q <= init_board;
      else if (commit)  board_q <= cap_q;
      else if (restore) board_q <= hist_dout;
      if (flag_load) begin
        chg_q <= chg_d;
        err_q <= err_d;
      end
    end
  end

  board_history #(
    .W     (BW),
    .DEPTH (UNDO_DEPTH),
    .CW    (CW)
  ) u_hist (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (board_q),
    .dout  (hist_dout),
    .count (hist_count)
  );

  assign board     = board_q;
  assign req_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign changed   = done & chg_q;
  assign err       = done & err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_board_select_commit.sv
// Randomised scoreboard bench for board_select_commit against a queue-based game-board model.
module tb_board_select_commit;

  localparam int TILE_W     = 12;
  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int NUM_SRC    = 3;
  localparam int UNDO_DEPTH = 4;
  localparam int BW         = TILE_W * ROWS * COLS;
  localparam int SW         = 2;
  localparam int CW         = 3;
  localparam int EW         = BW + 2 + CW;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  init;
  logic [BW-1:0]         init_board;
  logic [NUM_SRC*BW-1:0] cand;
  logic [SW-1:0]         sel;
  logic                  req_valid;
  logic                  req_ready;
  logic                  undo_req;
  logic [BW-1:0]         board;
  logic                  done;
  logic                  changed;
  logic                  err;
  logic [CW-1:0]         hist_count;
  logic [1:0]            state_dbg;

  board_select_commit #(
    .TILE_W     (TILE_W),
    .ROWS       (ROWS),
    .COLS       (COLS),
    .NUM_SRC    (NUM_SRC),
    .UNDO_DEPTH (UNDO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .init_board (init_board),
    .cand       (cand),
    .sel        (sel),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .undo_req   (undo_req),
    .board      (board),
    .done       (done),
    .changed    (changed),
    .err        (err),
    .hist_count (hist_count),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model and scoreboard
  logic [BW-1:0] m_board;
  logic [BW-1:0] m_hist[$];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack_exp(input logic [BW-1:0] b, input logic c, input logic e,
                                             input int hc);
    return {b, c, e, CW'(hc)};
  endfunction

  task automatic model_commit(input int s, input logic [NUM_SRC*BW-1:0] cv);
    logic [BW-1:0] c;
    if (s >= NUM_SRC) begin
      exp_q.push_back(pack_exp(m_board, 1'b0, 1'b1, m_hist.size()));
    end else begin
      c = cv[s*BW +: BW];
      if (c == m_board) begin
        exp_q.push_back(pack_exp(m_board, 1'b0, 1'b0, m_hist.size()));
      end else begin
        m_hist.push_back(m_board);
        if (m_hist.size() > UNDO_DEPTH) void'(m_hist.pop_front());
        m_board = c;
        exp_q.push_back(pack_exp(m_board, 1'b1, 1'b0, m_hist.size()));
      end
    end
  endtask

  task automatic model_undo();
    if (m_hist.size() > 0) begin
      m_board = m_hist.pop_back();
      exp_q.push_back(pack_exp(m_board, 1'b1, 1'b0, m_hist.size()));
    end else begin
      exp_q.push_back(pack_exp(m_board, 1'b0, 1'b1, 0));
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_board", board, mon_e[EW-1 -: BW]);
        chk("done_changed", BW'(changed), BW'(mon_e[CW+1]));
        chk("done_err", BW'(err), BW'(mon_e[CW]));
        chk("done_hist_count", BW'(hist_count), BW'(mon_e[CW-1:0]));
      end
    end
  end

  // ---------------- driver tasks
  function automatic logic [BW-1:0] rand_board();
    logic [BW-1:0] b;
    for (int i = 0; i < ROWS * COLS; i++)
      b[i*TILE_W +: TILE_W] = ($urandom_range(0, 1) == 1) ? TILE_W'(1 << $urandom_range(1, 11)) : '0;
    return b;
  endfunction

  function automatic logic [NUM_SRC*BW-1:0] rand_cands();
    logic [NUM_SRC*BW-1:0] cv;
    for (int i = 0; i < NUM_SRC; i++) cv[i*BW +: BW] = rand_board();
    return cv;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout actual=%b required=1", req_ready);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || req_ready !== 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout actual=pending%0d_ready%b required=pending0_ready1",
               exp_q.size(), req_ready);
    end
  endtask

  task automatic check_static(input string tag);
    chk({tag, "_board"}, board, m_board);
    chk({tag, "_hist_count"}, BW'(hist_count), BW'(m_hist.size()));
    chk({tag, "_req_ready"}, BW'(req_ready), BW'(1));
    chk({tag, "_done"}, BW'(done), BW'(0));
  endtask

  // Returns at the falling edge of cycle 1 (request accepted in cycle 0).
  task automatic issue_commit(input int s, input logic [NUM_SRC*BW-1:0] cv, input logic with_undo);
    wait_ready();
    sel       = SW'(s);
    cand      = cv;
    req_valid = 1'b1;
    undo_req  = with_undo;
    model_commit(s, cv);
    @(negedge clk);
    req_valid = 1'b0;
    undo_req  = 1'b0;
    cand      = rand_cands();
  endtask

  task automatic issue_undo();
    wait_ready();
    undo_req = 1'b1;
    model_undo();
    @(negedge clk);
    undo_req = 1'b0;
  endtask

  task automatic do_init(input logic [BW-1:0] b);
    wait_ready();
    init       = 1'b1;
    init_board = b;
    m_board    = b;
    m_hist.delete();
    @(negedge clk);
    init = 1'b0;
  endtask

  // ---------------- stimulus
  logic [NUM_SRC*BW-1:0] cv;
  logic [BW-1:0]         b;
  logic [BW-1:0]         saved[5];

  initial begin
    rst        = 1'b1;
    init       = 1'b0;
    init_board = '0;
    cand       = '0;
    sel        = '0;
    req_valid  = 1'b0;
    undo_req   = 1'b0;
    m_board    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_static("reset");
    chk("reset_changed", BW'(changed), BW'(0));
    chk("reset_err", BW'(err), BW'(0));

    // init with tile[0][0]=2
    b = '0;
    b[0 +: TILE_W] = TILE_W'(2);
    do_init(b);
    check_static("init");

    // commit sel=2 whose candidate has tile[0][3]=2, with latency check
    cv = rand_cands();
    b  = '0;
    b[3*TILE_W +: TILE_W] = TILE_W'(2);
    cv[2*BW +: BW] = b;
    issue_commit(2, cv, 1'b0);
    chk("latency_cycle1_done", BW'(done), BW'(0));
    @(negedge clk);
    chk("latency_cycle2_done", BW'(done), BW'(1));
    wait_idle();
    check_static("after_commit");

    // commit of a candidate identical to the live board
    cv = rand_cands();
    cv[1*BW +: BW] = m_board;
    issue_commit(1, cv, 1'b0);
    wait_idle();

    // five distinct commits then five undos
    for (int k = 0; k < 5; k++) begin
      cv = rand_cands();
      b  = rand_board();
      b[(ROWS*COLS-1)*TILE_W +: TILE_W] = TILE_W'(100 + k);
      cv[0 +: BW] = b;
      saved[k] = b;
      issue_commit(0, cv, 1'b0);
      wait_idle();
    end
    for (int k = 0; k < 5; k++) begin
      issue_undo();
      wait_idle();
    end
    chk("undo_oldest_survivor", board, saved[0]);

    // out-of-range select
    issue_commit(3, rand_cands(), 1'b0);
    wait_idle();

    // commit and undo together: commit wins
    cv = rand_cands();
    cv[BW +: BW] = ~m_board;
    issue_commit(1, cv, 1'b1);
    wait_idle();
    check_static("commit_beats_undo");

    // init during DONE is ignored
    cv = rand_cands();
    cv[0 +: BW] = ~m_board;
    issue_commit(0, cv, 1'b0);
    @(negedge clk);
    init       = 1'b1;
    init_board = rand_board();
    @(negedge clk);
    init = 1'b0;
    wait_idle();
    check_static("init_in_done");

    // randomised mix
    for (int n = 0; n < 150; n++) begin
      int op;
      int s;
      op = $urandom_range(0, 9);
      if (op == 0) begin
        do_init(rand_board());
        check_static("rand_init");
      end else if (op <= 3) begin
        issue_undo();
      end else begin
        s  = $urandom_range(0, 3);
        cv = rand_cands();
        if (s < NUM_SRC && $urandom_range(0, 3) == 0) cv[s*BW +: BW] = m_board;
        issue_commit(s, cv, ($urandom_range(0, 4) == 0));
      end
      wait_idle();
    end

    // reset during CMP aborts without commit or done
    wait_ready();
    cv = rand_cands();
    cv[0 +: BW] = ~m_board;
    sel       = '0;
    cand      = cv;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    m_board   = '0;
    m_hist.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_static("reset_in_cmp");

    wait_idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected actual=%0d required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
